instruction_cache: RTL and testbench
====================================

INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 Parameter NUM_SETS, default 8, number of direct-mapped lines (power of two), each holding one 128-bit block.
REQ-002 clock  input  1  system clock; all state updates on posedge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 read  input  1  CPU fetch request, level; address held stable while busywait=1.
REQ-005 address  input  32  CPU byte address; [3:2] word offset, [4+log2(NUM_SETS)-1:4] index, remaining upper bits tag.
REQ-006 flush  input  1  single-cycle pulse invalidating all lines.
REQ-007 instruction  output  32  fetched word.
REQ-008 busywait  output  1  CPU stall.
REQ-009 mem_read  output  1  block read request to instruction memory.
REQ-010 mem_address  output  28  block address (address[31:4]).
REQ-011 mem_readdata  input  128  returned block; byte 0 in [7:0].
REQ-012 mem_busywait  input  1  memory busy; high while block read in progress.

Function
REQ-013 Hit = read & valid[index] & (tag_array[index]==tag); evaluated combinationally in IDLE.
REQ-014 On hit: busywait=0 same cycle; instruction = word [offset] of the line (offset 0 -> bits [31:0], offset 3 -> bits [127:96]).
REQ-015 On miss in IDLE: busywait=1 combinationally; next posedge enters MEM_READ.
REQ-016 FSM states IDLE, MEM_READ, UPDATE; IDLE->MEM_READ on read & miss; MEM_READ->UPDATE on posedge with mem_busywait=0, excluding the first MEM_READ cycle; UPDATE->IDLE unconditionally.
REQ-017 MEM_READ: mem_read=1, mem_address=address[31:4], busywait=1; mem_read held high until leaving MEM_READ.
REQ-018 UPDATE: mem_read=0, busywait=1; on posedge, line[index]<=mem_readdata, tag_array[index]<=tag, valid[index]<=1.
REQ-019 After UPDATE, IDLE re-evaluates: the retried access hits; miss-to-busywait-low latency = memory latency + 2 cycles.
REQ-020 In IDLE with read=0: busywait=0, mem_read=0, instruction holds last value.
REQ-021 Flush in IDLE: all valid bits cleared at that posedge; an access in the same cycle is treated as a miss.
REQ-022 Flush in MEM_READ/UPDATE: all valid bits cleared; refill completes; UPDATE installs line with valid=0; next IDLE access misses again.
REQ-023 Replacement: refill overwrites the indexed line unconditionally; no write path.

Reset
REQ-024 reset_n low: state=IDLE, all valid=0, mem_read=0, busywait=0, instruction=32'h0, counters=0; tag/data arrays not reset.
REQ-025 Reset asserted mid-refill aborts the refill; no line installed; mem_read drops immediately.

Configuration
REQ-026 ICACHE_PERF_CNT_EN defined: outputs hit_count[15:0], miss_count[15:0]; counts taken once per IDLE evaluation with read=1 (hit) or IDLE->MEM_READ transition (miss); saturate at 16'hFFFF.
REQ-027 ICACHE_PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-028 Shared package icache_pkg holds FSM state enum, BLOCK_W=128, MEM_ADDR_W=28, tag/index width functions of NUM_SETS.
REQ-029 One sub-module icache_word_sel (128-bit block, 2-bit offset -> 32-bit word).

Verification
REQ-030 Reset, read=1, address=0x00 with memory word0=0x08020005 -> mem_read=1, mem_address=0; after mem_busywait falls + 2 cycles, instruction=0x08020005, busywait=0.
REQ-031 Following read address=0x0C -> same-cycle hit, instruction=0xF0000201, mem_read never asserted.
REQ-032 Read 0x80 (same index 0 as 0x00, NUM_SETS=8) -> miss, line replaced; then read 0x00 -> miss again.
REQ-033 Flush pulse during MEM_READ for 0x10 -> refill completes, retried read 0x10 misses again (second mem_read).
REQ-034 reset_n low two cycles into MEM_READ -> mem_read=0, busywait=0, state IDLE; read 0x00 then misses.
REQ-035 ICACHE_PERF_CNT_EN set, sequence 0x00,0x04,0x08,0x80 -> miss_count=2, hit_count=2 after completion.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and widths for the direct-mapped instruction cache.
// Optional perf counters are enabled with ICACHE_PERF_CNT_EN.
package icache_pkg;

  localparam int BLOCK_W    = 128;
  localparam int MEM_ADDR_W = 28;
  localparam int WORD_W     = 32;

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    UPDATE
  } state_e;

  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int num_sets);
    return MEM_ADDR_W - idx_w(num_sets);
  endfunction

endpackage

// File: rtl/icache_word_sel.sv
// Picks one 32-bit word out of a 128-bit cache block.
// Word 0 sits in the least significant bits.
module icache_word_sel
  import icache_pkg::*;
(
  input  logic [BLOCK_W-1:0] i_block,
  input  logic [1:0]         i_offset,
  output logic [WORD_W-1:0]  o_word
);

  always_comb begin
    o_word = i_block[31:0];
    unique case (i_offset)
      2'd0: o_word = i_block[31:0];
      2'd1: o_word = i_block[63:32];
      2'd2: o_word = i_block[95:64];
      2'd3: o_word = i_block[127:96];
      default: o_word = i_block[31:0];
    endcase
  end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache with IDLE/MEM_READ/UPDATE refill FSM.
// Define ICACHE_PERF_CNT_EN to add saturating hit/miss counters.
module instruction_cache
  import icache_pkg::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  read,
  input  logic [31:0]           address,
  input  logic                  flush,
  output logic [31:0]           instruction,
  output logic                  busywait,
  output logic                  mem_read,
  output logic [MEM_ADDR_W-1:0] mem_address,
  input  logic [BLOCK_W-1:0]    mem_readdata,
  input  logic                  mem_busywait
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
`endif
);

  localparam int IW = idx_w(NUM_SETS);
  localparam int TW = tag_w(NUM_SETS);

  logic [BLOCK_W-1:0] r_data [NUM_SETS];
  logic [TW-1:0]      r_tag  [NUM_SETS];
  logic [NUM_SETS-1:0] r_valid;
  state_e             r_state;
  logic               r_first;
  logic               r_flushed;
  logic [31:0]        r_instr;

  logic [IW-1:0]      w_index;
  logic [TW-1:0]      w_tag;
  logic [1:0]         w_offset;
  logic [31:0]        w_word;
  logic               w_idle;
  logic               w_hit;
  logic               w_miss;
  logic               w_unused_bits;

  assign w_index  = address[4 +: IW];
  assign w_tag    = address[31 -: TW];
  assign w_offset = address[3:2];
  assign w_unused_bits = &{1'b0, address[1:0]};

  icache_word_sel u_word_sel (
    .i_block  (r_data[w_index]),
    .i_offset (w_offset),
    .o_word   (w_word)
  );

  // A flush in the same cycle makes the access a miss.
  assign w_idle = (r_state == IDLE);
  assign w_hit  = w_idle & read & ~flush & r_valid[w_index]
                & (r_tag[w_index] == w_tag);
  assign w_miss = w_idle & read & ~w_hit;

  assign busywait    = reset_n & (w_miss | ~w_idle);
  assign mem_read    = (r_state == MEM_READ);
  assign mem_address = address[31:4];
  assign instruction = w_hit ? w_word : r_instr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_valid   <= '0;
      r_first   <= 1'b0;
      r_flushed <= 1'b0;
      r_instr   <= '0;
    end else begin
      if (w_hit) r_instr <= w_word;
      unique case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_state   <= MEM_READ;
            r_first   <= 1'b1;
            r_flushed <= 1'b0;
          end
        end
        MEM_READ: begin
          r_first <= 1'b0;
          if (!r_first && !mem_busywait) r_state <= UPDATE;
        end
        UPDATE: begin
          r_state          <= IDLE;
          r_valid[w_index] <= ~(r_flushed | flush);
        end
        default: r_state <= IDLE;
      endcase
      if (flush) r_valid <= '0;
      if (flush && !w_idle) r_flushed <= 1'b1;
    end
  end

  // Storage arrays are only qualified by the valid bits, so no reset.
  always_ff @(posedge clock) begin
    if (r_state == UPDATE) begin
      r_data[w_index] <= mem_readdata;
      r_tag[w_index]  <= w_tag;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;
  logic        r_retry;

  // The hit right after a refill completes the miss and is not counted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_retry    <= 1'b0;
    end else begin
      r_retry <= (r_state == UPDATE);
      if (w_hit && !r_retry && r_hit_cnt != 16'hFFFF)
        r_hit_cnt <= r_hit_cnt + 16'd1;
      if (w_miss && r_miss_cnt != 16'hFFFF)
        r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache with a latency-modelled memory.
// Perf counter checks are built in when ICACHE_PERF_CNT_EN is defined.
module tb_instruction_cache;

  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         read;
  logic [31:0]  address;
  logic         flush;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef ICACHE_PERF_CNT_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int n_memreads = 0;
  int mbw_fall_cyc = 0;
  int done_cyc = 0;
  logic [31:0] sb[$];

  instruction_cache #(.NUM_SETS(8)) dut (
    .clock        (clk),
    .reset_n      (reset_n),
    .read         (read),
    .address      (address),
    .flush        (flush),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [31:0] w;
    if (a[31:4] == 28'h0) begin
      case (a[3:2])
        2'd0: w = 32'h08020005;
        2'd1: w = 32'h00A00093;
        2'd2: w = 32'h12345678;
        default: w = 32'hF0000201;
      endcase
    end else begin
      w = {a[31:2], 2'b00} ^ 32'hC3A50000;
    end
    return w;
  endfunction

  function automatic logic [127:0] block_of(input logic [27:0] b);
    logic [127:0] blk;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] kk;
      kk = k[1:0];
      blk[32*k +: 32] = word_of({b, kk, 2'b00});
    end
    return blk;
  endfunction

  assign mem_readdata = block_of(mem_address);

  // Memory: busy LAT cycles after seeing a new mem_read, then holds data.
  bit mbusy = 0;
  bit mdone = 0;
  int mcnt  = 0;
  always @(posedge clk) begin
    #1;
    if (!mem_read) begin
      mbusy = 0; mdone = 0; mem_busywait = 1'b0;
    end else if (!mbusy && !mdone) begin
      mbusy = 1; mcnt = LAT; mem_busywait = 1'b1;
    end else if (mbusy) begin
      mcnt--;
      if (mcnt == 0) begin
        mbusy = 0; mdone = 1; mem_busywait = 1'b0;
      end
    end
  end

  logic prev_mr = 1'b0;
  logic prev_mbw = 1'b0;
  always @(posedge clk) begin
    #2;
    cyc++;
    if (mem_read && !prev_mr) n_memreads++;
    if (!mem_busywait && prev_mbw) mbw_fall_cyc = cyc;
    prev_mr = mem_read;
    prev_mbw = mem_busywait;
  end

  // Starts at a negedge, returns at a later negedge after the CPU accepted.
  task automatic fetch(input logic [31:0] a, input bit exp_miss,
                       input int exp_reads, input int fl_at);
    int n0;
    int cycles;
    bit addr_ok;
    logic [31:0] exp;
    n0 = n_memreads;
    addr_ok = 1;
    read = 1'b1;
    address = a;
    flush = (fl_at == 0);
    sb.push_back(word_of(a));
    #1;
    checks++;
    if (busywait !== exp_miss) begin
      fails++;
      $display("FAIL busywait_first @%h: got %b expected %b", a, busywait, exp_miss);
    end
    cycles = 0;
    while (busywait === 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
      flush = (cycles == fl_at);
      if (mem_read && mem_address !== a[31:4]) addr_ok = 0;
    end
    flush = 1'b0;
    done_cyc = cyc;
    checks++;
    if (cycles >= 100) begin
      fails++;
      $display("FAIL timeout @%h: busywait stuck after %0d cycles, expected release", a, cycles);
    end
    exp = sb.pop_front();
    checks++;
    if (instruction !== exp) begin
      fails++;
      $display("FAIL instruction @%h: got %h expected %h", a, instruction, exp);
    end
    checks++;
    if ((n_memreads - n0) != exp_reads || !addr_ok) begin
      fails++;
      $display("FAIL mem_reads @%h: got %0d (addr_ok=%0d) expected %0d (addr_ok=1)",
               a, n_memreads - n0, addr_ok, exp_reads);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    read = 1'b1;
    address = 32'h0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busywait !== 1'b0 || mem_read !== 1'b0 || instruction !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: got bw=%b mr=%b instr=%h expected 0 0 00000000",
               busywait, mem_read, instruction);
    end
`ifdef ICACHE_PERF_CNT_EN
    checks++;
    if (hit_count !== 16'h0 || miss_count !== 16'h0) begin
      fails++;
      $display("FAIL reset_counters: got %h/%h expected 0000/0000", hit_count, miss_count);
    end
`endif
    read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_miss_fill();
    fetch(32'h00, 1'b1, 1, -1);
    checks++;
    if ((done_cyc - mbw_fall_cyc) != 2) begin
      fails++;
      $display("FAIL miss_latency: got %0d expected 2 cycles after mem_busywait fall",
               done_cyc - mbw_fall_cyc);
    end
    read = 1'b0;
    address = 32'h40;
    #1;
    checks++;
    if (busywait !== 1'b0 || mem_read !== 1'b0 || instruction !== 32'h08020005) begin
      fails++;
      $display("FAIL idle_hold: got bw=%b mr=%b instr=%h expected 0 0 08020005",
               busywait, mem_read, instruction);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    fetch(32'h0C, 1'b0, 0, -1);
    fetch(32'h04, 1'b0, 0, -1);
    fetch(32'h08, 1'b0, 0, -1);
    fetch(32'h00, 1'b0, 0, -1);
  endtask

  task automatic test_replace();
    fetch(32'h80, 1'b1, 1, -1);
    fetch(32'h84, 1'b0, 0, -1);
    fetch(32'h00, 1'b1, 1, -1);
    fetch(32'h2C, 1'b1, 1, -1);
    fetch(32'h00, 1'b0, 0, -1);
  endtask

  task automatic test_flush();
    read = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    fetch(32'h00, 1'b1, 1, -1);
    fetch(32'h04, 1'b1, 1, 0);
    fetch(32'h10, 1'b1, 2, 2);
    fetch(32'h14, 1'b0, 0, -1);
    fetch(32'h20, 1'b1, 2, 5);
    fetch(32'h2C, 1'b0, 0, -1);
  endtask

  task automatic test_reset_midfill();
    read = 1'b1;
    address = 32'h40;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || busywait !== 1'b0 || instruction !== 32'h0) begin
      fails++;
      $display("FAIL reset_midfill: got mr=%b bw=%b instr=%h expected 0 0 00000000",
               mem_read, busywait, instruction);
    end
    read = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    fetch(32'h00, 1'b1, 1, -1);
    fetch(32'h40, 1'b1, 1, -1);
    read = 1'b0;
    @(negedge clk);
  endtask

`ifdef ICACHE_PERF_CNT_EN
  task automatic test_perf_cnt();
    do_reset();
    fetch(32'h00, 1'b1, 1, -1);
    fetch(32'h04, 1'b0, 0, -1);
    fetch(32'h08, 1'b0, 0, -1);
    fetch(32'h80, 1'b1, 1, -1);
    read = 1'b0;
    @(negedge clk);
    checks++;
    if (hit_count !== 16'd2 || miss_count !== 16'd2) begin
      fails++;
      $display("FAIL perf_counts: got hit=%0d miss=%0d expected hit=2 miss=2",
               hit_count, miss_count);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    read = 1'b0;
    address = 32'h0;
    flush = 1'b0;
    mem_busywait = 1'b0;
    @(negedge clk);
    test_reset();
    test_miss_fill();
    test_back_to_back();
    test_replace();
    test_flush();
    test_reset_midfill();
`ifdef ICACHE_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
